// File: rtl/multi_ball_hit_controller.sv
// Frame-based collision resolver for NUM_BALLS balls: accumulates overlap events, then scans pairs and borders.
// Optional macro HIT_CTRL_DAMPING_EN: border reflections are damped by v - (v >>> 3).
module multi_ball_hit_controller #(
   parameter int NUM_BALLS    = 2,
   parameter int VEL_W        = 11,
   parameter int BALL_SIZE    = 32,
   parameter int EDGE_MARGIN  = 4,
   parameter int TOP_OFFSET   = 0,
   parameter int DOWN_OFFSET  = 479,
   parameter int LEFT_OFFSET  = 0,
   parameter int RIGHT_OFFSET = 639
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       startOfFrame,
   input  logic [NUM_BALLS-1:0]       ballDR,
   input  logic                       bordersDR,
   input  logic                       holesDR,
   input  logic [2:0]                 holeNumber,
   input  logic [NUM_BALLS*11-1:0]    ballPosX,
   input  logic [NUM_BALLS*11-1:0]    ballPosY,
   input  logic [NUM_BALLS*VEL_W-1:0] ballVelX,
   input  logic [NUM_BALLS*VEL_W-1:0] ballVelY,
   output logic [NUM_BALLS*VEL_W-1:0] ballVelXOut,
   output logic [NUM_BALLS*VEL_W-1:0] ballVelYOut,
   output logic [NUM_BALLS-1:0]       collisionOccurred,
   output logic [NUM_BALLS-1:0]       holeHit,
   output logic [NUM_BALLS*3-1:0]     holeNum,
   output logic                       resultValid,
   output logic                       busy
);
   localparam int IDX_W = (NUM_BALLS > 2) ? $clog2(NUM_BALLS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BALLS - 1);
   localparam logic [IDX_W-1:0] LAST_PI   = IDX_W'(NUM_BALLS - 2);
   localparam logic [11:0]      LEFT_LIM  = 12'(LEFT_OFFSET + EDGE_MARGIN);
   localparam logic [11:0]      RIGHT_LIM = 12'(RIGHT_OFFSET - EDGE_MARGIN);
   localparam logic [11:0]      TOP_LIM   = 12'(TOP_OFFSET + EDGE_MARGIN);
   localparam logic [11:0]      DOWN_LIM  = 12'(DOWN_OFFSET - EDGE_MARGIN);
   localparam logic [11:0]      SIZE_12   = 12'(BALL_SIZE);
   localparam logic [VEL_W-1:0] VEL_MIN   = {1'b1, {(VEL_W-1){1'b0}}};
   localparam logic [VEL_W-1:0] VEL_MAX   = {1'b0, {(VEL_W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, SCAN_PAIRS, SCAN_BORDERS, DONE} state_t;
   typedef logic [NUM_BALLS-1:0][VEL_W-1:0] vel_arr_t;
   typedef logic [NUM_BALLS-1:0][10:0]      pos_arr_t;
   typedef logic [NUM_BALLS-1:0][2:0]       hnum_arr_t;
   typedef logic [NUM_BALLS-1:0][NUM_BALLS-1:0] pair_arr_t;

   state_t                 state_q, state_d;
   logic                   pending_q, pending_d, busy_q, busy_d, result_valid_q, result_valid_d;
   logic [NUM_BALLS-1:0]   border_acc_q, border_acc_d, hole_acc_q, hole_acc_d;
   hnum_arr_t              hole_num_acc_q, hole_num_acc_d;
   pair_arr_t              pair_acc_q, pair_acc_d;
   logic [NUM_BALLS-1:0]   border_w_q, border_w_d, hole_w_q, hole_w_d, claimed_q, claimed_d;
   hnum_arr_t              hole_num_w_q, hole_num_w_d;
   pair_arr_t              pair_w_q, pair_w_d;
   vel_arr_t               snap_vx_q, snap_vx_d, snap_vy_q, snap_vy_d;
   pos_arr_t               snap_px_q, snap_px_d, snap_py_q, snap_py_d;
   vel_arr_t               res_vx_q, res_vx_d, res_vy_q, res_vy_d;
   logic [IDX_W-1:0]       pi_q, pi_d, pj_q, pj_d, bi_q, bi_d;
   vel_arr_t               vx_out_q, vx_out_d, vy_out_q, vy_out_d;
   logic [NUM_BALLS-1:0]   coll_out_q, coll_out_d, hole_hit_q, hole_hit_d;
   hnum_arr_t              hole_num_out_q, hole_num_out_d;

   logic                   snap, x_hit, y_hit;
   logic [NUM_BALLS-1:0]   border_base, hole_base;
   pair_arr_t              pair_base;
   logic [VEL_W-1:0]       bvx, bvy;
   logic [11:0]            bpx, bpy;

   // Saturating negation; the most negative value maps to the most positive one.
   function automatic logic [VEL_W-1:0] reflect(input logic [VEL_W-1:0] v);
      logic [VEL_W-1:0]        n;
      logic signed [VEL_W-1:0] damp;
      n    = (v == VEL_MIN) ? VEL_MAX : (~v + VEL_W'(1));
      damp = '0;
`ifdef HIT_CTRL_DAMPING_EN
      damp = $signed(n) >>> 3;
`endif
      return n - damp;
   endfunction

   always_comb begin
      // NOTE: every _d starts from its _q value so no branch below can leave one unassigned (no latches).
      state_d = state_q;  pending_d = pending_q;  busy_d = busy_q;  result_valid_d = 1'b0;
      border_w_d = border_w_q;  hole_w_d = hole_w_q;  hole_num_w_d = hole_num_w_q;  pair_w_d = pair_w_q;
      claimed_d = claimed_q;  snap_vx_d = snap_vx_q;  snap_vy_d = snap_vy_q;
      snap_px_d = snap_px_q;  snap_py_d = snap_py_q;  res_vx_d = res_vx_q;  res_vy_d = res_vy_q;
      pi_d = pi_q;  pj_d = pj_q;  bi_d = bi_q;
      vx_out_d = vx_out_q;  vy_out_d = vy_out_q;  coll_out_d = coll_out_q;
      hole_hit_d = hole_hit_q;  hole_num_out_d = hole_num_out_q;

      // Events on the snapshot cycle start the next frame's accumulation.
      snap        = (state_q == IDLE) && (startOfFrame || pending_q);
      border_base = snap ? '0 : border_acc_q;
      hole_base   = snap ? '0 : hole_acc_q;
      pair_base   = snap ? '0 : pair_acc_q;
      border_acc_d   = border_base | (ballDR & {NUM_BALLS{bordersDR}});
      hole_acc_d     = hole_base | (ballDR & {NUM_BALLS{holesDR}});
      hole_num_acc_d = hole_num_acc_q;
      pair_acc_d     = pair_base;
      for (int i = 0; i < NUM_BALLS; i++) begin
         if (ballDR[i] && holesDR && !hole_base[i]) hole_num_acc_d[i] = holeNumber;
         for (int j = i + 1; j < NUM_BALLS; j++)
            if (ballDR[i] && ballDR[j]) pair_acc_d[i][j] = 1'b1;
      end
      if (snap)              pending_d = 1'b0;
      else if (startOfFrame) pending_d = 1'b1;

      bvx   = snap_vx_q[bi_q];
      bvy   = snap_vy_q[bi_q];
      bpx   = {1'b0, snap_px_q[bi_q]};
      bpy   = {1'b0, snap_py_q[bi_q]};
      x_hit = (bvx[VEL_W-1] && (bpx < LEFT_LIM)) ||
              (!bvx[VEL_W-1] && (|bvx) && (bpx + SIZE_12 > RIGHT_LIM));
      y_hit = (bvy[VEL_W-1] && (bpy < TOP_LIM)) ||
              (!bvy[VEL_W-1] && (|bvy) && (bpy + SIZE_12 > DOWN_LIM));

      unique case (state_q)
         IDLE: if (snap) begin
            snap_vx_d = ballVelX;  snap_vy_d = ballVelY;  snap_px_d = ballPosX;  snap_py_d = ballPosY;
            border_w_d = border_acc_q;  hole_w_d = hole_acc_q;
            hole_num_w_d = hole_num_acc_q;  pair_w_d = pair_acc_q;
            claimed_d = '0;  res_vx_d = '0;  res_vy_d = '0;
            pi_d = '0;  pj_d = IDX_W'(1);  busy_d = 1'b1;  state_d = SCAN_PAIRS;
         end
         SCAN_PAIRS: begin
            if (pair_w_q[pi_q][pj_q] && !claimed_q[pi_q] && !claimed_q[pj_q] &&
                !hole_w_q[pi_q] && !hole_w_q[pj_q]) begin
               res_vx_d[pi_q] = snap_vx_q[pj_q];  res_vy_d[pi_q] = snap_vy_q[pj_q];
               res_vx_d[pj_q] = snap_vx_q[pi_q];  res_vy_d[pj_q] = snap_vy_q[pi_q];
               claimed_d[pi_q] = 1'b1;  claimed_d[pj_q] = 1'b1;
            end
            if (pj_q != LAST_IDX) pj_d = pj_q + IDX_W'(1);
            else if (pi_q != LAST_PI) begin
               pi_d = pi_q + IDX_W'(1);  pj_d = pi_q + IDX_W'(2);
            end else begin
               bi_d = '0;  state_d = SCAN_BORDERS;
            end
         end
         SCAN_BORDERS: begin
            // A border hit replaces any swap result; with no qualifying side both axes flip.
            if (border_w_q[bi_q] && !hole_w_q[bi_q]) begin
               res_vx_d[bi_q]  = (x_hit || !y_hit) ? reflect(bvx) : bvx;
               res_vy_d[bi_q]  = (y_hit || !x_hit) ? reflect(bvy) : bvy;
               claimed_d[bi_q] = 1'b1;
            end
            if (bi_q == LAST_IDX) state_d = DONE;
            else                  bi_d = bi_q + IDX_W'(1);
         end
         DONE: begin
            for (int i = 0; i < NUM_BALLS; i++) begin
               hole_hit_d[i]     = hole_w_q[i];
               hole_num_out_d[i] = hole_w_q[i] ? hole_num_w_q[i] : 3'd0;
               coll_out_d[i]     = claimed_q[i] && !hole_w_q[i];
               vx_out_d[i]       = coll_out_d[i] ? res_vx_q[i] : '0;
               vy_out_d[i]       = coll_out_d[i] ? res_vy_q[i] : '0;
            end
            result_valid_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;  pending_q <= 1'b0;  busy_q <= 1'b0;  result_valid_q <= 1'b0;
         border_acc_q <= '0;  hole_acc_q <= '0;  hole_num_acc_q <= '0;  pair_acc_q <= '0;
         border_w_q <= '0;  hole_w_q <= '0;  hole_num_w_q <= '0;  pair_w_q <= '0;  claimed_q <= '0;
         snap_vx_q <= '0;  snap_vy_q <= '0;  snap_px_q <= '0;  snap_py_q <= '0;
         res_vx_q <= '0;  res_vy_q <= '0;  pi_q <= '0;  pj_q <= '0;  bi_q <= '0;
         vx_out_q <= '0;  vy_out_q <= '0;  coll_out_q <= '0;  hole_hit_q <= '0;  hole_num_out_q <= '0;
      end else begin
         // NOTE: state is only ever written with <= here; all next-state logic lives in always_comb.
         state_q <= state_d;  pending_q <= pending_d;  busy_q <= busy_d;  result_valid_q <= result_valid_d;
         border_acc_q <= border_acc_d;  hole_acc_q <= hole_acc_d;
         hole_num_acc_q <= hole_num_acc_d;  pair_acc_q <= pair_acc_d;
         border_w_q <= border_w_d;  hole_w_q <= hole_w_d;  hole_num_w_q <= hole_num_w_d;
         pair_w_q <= pair_w_d;  claimed_q <= claimed_d;
         snap_vx_q <= snap_vx_d;  snap_vy_q <= snap_vy_d;  snap_px_q <= snap_px_d;  snap_py_q <= snap_py_d;
         res_vx_q <= res_vx_d;  res_vy_q <= res_vy_d;  pi_q <= pi_d;  pj_q <= pj_d;  bi_q <= bi_d;
         vx_out_q <= vx_out_d;  vy_out_q <= vy_out_d;  coll_out_q <= coll_out_d;
         hole_hit_q <= hole_hit_d;  hole_num_out_q <= hole_num_out_d;
      end
   end

   assign ballVelXOut       = vx_out_q;
   assign ballVelYOut       = vy_out_q;
   assign collisionOccurred = coll_out_q;
   assign holeHit           = hole_hit_q;
   assign holeNum           = hole_num_out_q;
   assign resultValid       = result_valid_q;
   assign busy              = busy_q;
endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// Self-checking bench for multi_ball_hit_controller (3 balls): border table, corner sequences, random frames.
module tb_multi_ball_hit_controller;
   localparam int N     = 3;
   localparam int VEL_W = 11;
   localparam int VMAX  = (1 << (VEL_W - 1)) - 1;
   localparam int BSZ   = 32;
   localparam int MRG   = 4;
   localparam int LEFT  = 0, RIGHT = 639, TOP = 0, DOWN = 479;
   localparam int LAT   = 1 + N * (N - 1) / 2 + N + 1;

   logic                   clk = 1'b0;
   logic                   resetN, startOfFrame, bordersDR, holesDR;
   logic [N-1:0]           ballDR;
   logic [2:0]             holeNumber;
   logic [N*11-1:0]        ballPosX, ballPosY;
   logic [N*VEL_W-1:0]     ballVelX, ballVelY, ballVelXOut, ballVelYOut;
   logic [N-1:0]           collisionOccurred, holeHit;
   logic [N*3-1:0]         holeNum;
   logic                   resultValid, busy;

   multi_ball_hit_controller #(.NUM_BALLS(N), .VEL_W(VEL_W)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
      .bordersDR(bordersDR), .holesDR(holesDR), .holeNumber(holeNumber),
      .ballPosX(ballPosX), .ballPosY(ballPosY), .ballVelX(ballVelX), .ballVelY(ballVelY),
      .ballVelXOut(ballVelXOut), .ballVelYOut(ballVelYOut), .collisionOccurred(collisionOccurred),
      .holeHit(holeHit), .holeNum(holeNum), .resultValid(resultValid), .busy(busy));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int b_vx[N], b_vy[N], b_px[N], b_py[N];
   bit m_border[N], m_hole[N], m_pair[N][N];
   int m_hnum[N];
   int e_vx[N], e_vy[N], e_coll[N], e_hh[N], e_hn[N];

   typedef struct { int vx, vy, px, py, exp_vx, exp_vy; } bvec_t;
   bvec_t tbl[12];

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int refl(input int v);
      int n;
      n = -v;
      if (n > VMAX) n = VMAX;
`ifdef HIT_CTRL_DAMPING_EN
      n = n - (n >>> 3);
`endif
      return n;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         m_border[i] = 0; m_hole[i] = 0; m_hnum[i] = 0;
         for (int j = 0; j < N; j++) m_pair[i][j] = 0;
      end
   endtask

   task automatic model_event(input logic [N-1:0] dr, input logic bd, input logic hl, input int hn);
      for (int i = 0; i < N; i++) begin
         if (dr[i] && bd) m_border[i] = 1;
         if (dr[i] && hl) begin
            if (!m_hole[i]) m_hnum[i] = hn;
            m_hole[i] = 1;
         end
         for (int j = i + 1; j < N; j++) if (dr[i] && dr[j]) m_pair[i][j] = 1;
      end
   endtask

   // Frame resolution straight from the rules: swaps in pair order, then border overrides.
   task automatic resolve();
      bit claimed[N];
      int rx[N], ry[N];
      bit xq, yq;
      for (int i = 0; i < N; i++) begin claimed[i] = 0; rx[i] = 0; ry[i] = 0; end
      for (int i = 0; i < N - 1; i++)
         for (int j = i + 1; j < N; j++)
            if (m_pair[i][j] && !claimed[i] && !claimed[j] && !m_hole[i] && !m_hole[j]) begin
               rx[i] = b_vx[j]; ry[i] = b_vy[j]; rx[j] = b_vx[i]; ry[j] = b_vy[i];
               claimed[i] = 1; claimed[j] = 1;
            end
      for (int i = 0; i < N; i++)
         if (m_border[i] && !m_hole[i]) begin
            xq = (b_vx[i] < 0 && b_px[i] < LEFT + MRG) || (b_vx[i] > 0 && b_px[i] + BSZ > RIGHT - MRG);
            yq = (b_vy[i] < 0 && b_py[i] < TOP + MRG) || (b_vy[i] > 0 && b_py[i] + BSZ > DOWN - MRG);
            if (!xq && !yq) begin xq = 1; yq = 1; end
            rx[i] = xq ? refl(b_vx[i]) : b_vx[i];
            ry[i] = yq ? refl(b_vy[i]) : b_vy[i];
            claimed[i] = 1;
         end
      for (int i = 0; i < N; i++) begin
         e_hh[i]   = m_hole[i] ? 1 : 0;
         e_hn[i]   = m_hole[i] ? m_hnum[i] : 0;
         e_coll[i] = (claimed[i] && !m_hole[i]) ? 1 : 0;
         e_vx[i]   = e_coll[i] ? rx[i] : 0;
         e_vy[i]   = e_coll[i] ? ry[i] : 0;
      end
      clear_model();
   endtask

   task automatic set_balls();
      for (int i = 0; i < N; i++) begin
         ballVelX[i*VEL_W +: VEL_W] = VEL_W'(b_vx[i]);
         ballVelY[i*VEL_W +: VEL_W] = VEL_W'(b_vy[i]);
         ballPosX[i*11 +: 11] = 11'(b_px[i]);
         ballPosY[i*11 +: 11] = 11'(b_py[i]);
      end
   endtask

   task automatic ev(input logic [N-1:0] dr, input logic bd, input logic hl, input int hn);
      ballDR = dr; bordersDR = bd; holesDR = hl; holeNumber = 3'(hn);
      model_event(dr, bd, hl, hn);
      tick();
      ballDR = '0; bordersDR = 0; holesDR = 0; holeNumber = 0;
   endtask

   task automatic wait_pulse(input int start, output int n);
      n = start;
      do begin
         tick();
         n++;
      end while (!resultValid && n < 40);
   endtask

   task automatic do_frame(input string tag);
      int n;
      startOfFrame = 1; tick(); startOfFrame = 0;
      resolve();
      wait_pulse(1, n);
      check({tag, "_rv_seen"}, int'(resultValid), 1);
   endtask

   task automatic check_all(input string tag);
      logic signed [VEL_W-1:0] gx, gy;
      for (int i = 0; i < N; i++) begin
         gx = ballVelXOut[i*VEL_W +: VEL_W];
         gy = ballVelYOut[i*VEL_W +: VEL_W];
         check($sformatf("%s_vx%0d", tag, i), int'(gx), e_vx[i]);
         check($sformatf("%s_vy%0d", tag, i), int'(gy), e_vy[i]);
         check($sformatf("%s_coll%0d", tag, i), int'(collisionOccurred[i]), e_coll[i]);
         check($sformatf("%s_hh%0d", tag, i), int'(holeHit[i]), e_hh[i]);
         check($sformatf("%s_hn%0d", tag, i), int'(holeNum[i*3 +: 3]), e_hn[i]);
      end
   endtask

   task automatic park_balls();
      for (int i = 0; i < N; i++) begin
         b_vx[i] = 10 * (i + 1); b_vy[i] = -7 * (i + 1);
         b_px[i] = 200 + 60 * i; b_py[i] = 200;
      end
      set_balls();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n, pulses;
      tbl[0]  = '{5, 3, 610, 100, -5, 3};
      tbl[1]  = '{-1024, 0, 2, 200, 1023, 0};
      tbl[2]  = '{4, -7, 300, 1, 4, 7};
      tbl[3]  = '{6, -2, 300, 300, -6, 2};
      tbl[4]  = '{-3, 9, 3, 460, 3, -9};
      tbl[5]  = '{0, 0, 0, 0, 0, 0};
      tbl[6]  = '{-1024, -1024, 100, 100, 1023, 1023};
      tbl[7]  = '{-2, 5, 4, 300, 2, -5};
      tbl[8]  = '{-2, 5, 3, 300, 2, 5};
      tbl[9]  = '{1, 1, 603, 300, -1, -1};
      tbl[10] = '{1, 1, 604, 300, -1, 1};
      tbl[11] = '{7, -8, 700, 2, -7, 8};

      resetN = 0; startOfFrame = 0; ballDR = '0; bordersDR = 0; holesDR = 0; holeNumber = 0;
      clear_model();
      park_balls();
      #3;
      check("rst_vx", int'(|ballVelXOut), 0);
      check("rst_vy", int'(|ballVelYOut), 0);
      check("rst_coll", int'(collisionOccurred), 0);
      check("rst_hh", int'(holeHit), 0);
      check("rst_hn", int'(holeNum), 0);
      check("rst_rv", int'(resultValid), 0);
      check("rst_busy", int'(busy), 0);
      tick(); tick();
      @(negedge clk) resetN = 1;
      tick();

      // Ball 0 moving right into the right border: latency and busy window.
      b_vx[0] = 5; b_vy[0] = 0; b_px[0] = 610; b_py[0] = 100; set_balls();
      ev(3'b001, 1, 0, 0);
      startOfFrame = 1; tick(); startOfFrame = 0;
      resolve();
      check("lat_busy_after_snap", int'(busy), 1);
      wait_pulse(1, n);
      check("lat_cycles", n, LAT);
      check("lat_busy_at_valid", int'(busy), 0);
      check("lat_coll", int'(collisionOccurred), 3'b001);
      check_all("lat");
      tick();
      check("rv_one_cycle", int'(resultValid), 0);

      // Table of single-ball border reflections on ball 0.
      for (int k = 0; k < 12; k++) begin
         logic signed [VEL_W-1:0] gx, gy;
         park_balls();
         b_vx[0] = tbl[k].vx; b_vy[0] = tbl[k].vy; b_px[0] = tbl[k].px; b_py[0] = tbl[k].py;
         set_balls();
         ev(3'b001, 1, 0, 0);
         do_frame($sformatf("tbl%0d", k));
         gx = ballVelXOut[0 +: VEL_W];
         gy = ballVelYOut[0 +: VEL_W];
         check($sformatf("tbl%0d_vx", k), int'(gx), tbl[k].exp_vx);
         check($sformatf("tbl%0d_vy", k), int'(gy), tbl[k].exp_vy);
         check($sformatf("tbl%0d_coll", k), int'(collisionOccurred), 3'b001);
      end

      // Chained overlaps: only the first pair in scan order swaps.
      park_balls();
      ev(3'b011, 0, 0, 0);
      ev(3'b110, 0, 0, 0);
      do_frame("chain");
      check("chain_coll", int'(collisionOccurred), 3'b011);
      check_all("chain");

      // Hole hit suppresses the swap with ball 0.
      park_balls();
      ev(3'b010, 0, 1, 5);
      ev(3'b011, 0, 0, 0);
      ev(3'b010, 0, 1, 2);
      do_frame("hole");
      check("hole_hh", int'(holeHit), 3'b010);
      check("hole_num1", int'(holeNum[3 +: 3]), 5);
      check("hole_coll", int'(collisionOccurred), 3'b000);
      check_all("hole");

      // Overlap on the snapshot cycle belongs to the next frame.
      park_balls();
      startOfFrame = 1; ballDR = 3'b011; tick(); startOfFrame = 0; ballDR = '0;
      resolve();
      model_event(3'b011, 0, 0, 0);
      wait_pulse(1, n);
      check("coinc1_coll", int'(collisionOccurred), 3'b000);
      check_all("coinc1");
      do_frame("coinc2");
      check("coinc2_coll", int'(collisionOccurred), 3'b011);
      check_all("coinc2");

      // Second strobe during a scan becomes pending; events keep accumulating.
      b_vx[0] = 11; b_vy[0] = -12; b_px[0] = 300; b_py[0] = 200;
      b_vx[1] = 13; b_vy[1] = 14;  b_px[1] = 350; b_py[1] = 200;
      b_vx[2] = -15; b_vy[2] = 16; b_px[2] = 400; b_py[2] = 200;
      set_balls();
      ev(3'b101, 0, 0, 0);
      startOfFrame = 1; tick(); startOfFrame = 0;
      resolve();
      tick();
      ev(3'b011, 0, 0, 0);
      ev(3'b100, 1, 0, 0);
      startOfFrame = 1; tick(); startOfFrame = 0;
      check("pend_busy", int'(busy), 1);
      wait_pulse(5, n);
      check("pend1_cycles", n, LAT);
      check("pend1_coll", int'(collisionOccurred), 3'b101);
      check_all("pend1");
      resolve();
      wait_pulse(0, n);
      check("pend2_cycles", n, LAT);
      check("pend2_coll", int'(collisionOccurred), 3'b111);
      check_all("pend2");
      tick(); tick(); tick();
      check_all("hold");

      // Randomised frames against the reference model.
      for (int f = 0; f < 40; f++) begin
         int nev;
         for (int i = 0; i < N; i++) begin
            b_vx[i] = ($urandom_range(0, 9) == 0) ? -1024 : int'($urandom_range(0, 2047)) - 1024;
            b_vy[i] = ($urandom_range(0, 9) == 0) ? -1024 : int'($urandom_range(0, 2047)) - 1024;
            b_px[i] = int'($urandom_range(0, 700));
            b_py[i] = int'($urandom_range(0, 520));
         end
         set_balls();
         nev = int'($urandom_range(1, 5));
         for (int e = 0; e < nev; e++)
            ev(N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)));
         do_frame($sformatf("rnd%0d", f));
         check_all($sformatf("rnd%0d", f));
      end

      // Reset in the middle of the pair scan.
      park_balls();
      ev(3'b001, 1, 0, 0);
      do_frame("pre_rst");
      check("pre_rst_coll", int'(collisionOccurred), 3'b001);
      ev(3'b011, 0, 0, 0);
      startOfFrame = 1; tick(); startOfFrame = 0;
      tick(); tick();
      #2 resetN = 0;
      #1;
      check("mid_rst_vx", int'(|ballVelXOut), 0);
      check("mid_rst_vy", int'(|ballVelYOut), 0);
      check("mid_rst_coll", int'(collisionOccurred), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_rv", int'(resultValid), 0);
      clear_model();
      @(negedge clk) resetN = 1;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (resultValid) pulses++;
      end
      check("no_rv_after_rst", pulses, 0);
      do_frame("post_rst");
      check_all("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
